// File: rtl/pu_compare_pkg.sv
// Shared definitions for the pu_compare sequencer: opcode encodings, the
// sequencer state type and the opcode field width.
package pu_compare_pkg;

    localparam int OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] CMP_EQ  = 3'd0;
    localparam logic [OP_WIDTH-1:0] CMP_LT  = 3'd1;
    localparam logic [OP_WIDTH-1:0] CMP_LTE = 3'd2;
    localparam logic [OP_WIDTH-1:0] CMP_GT  = 3'd3;
    localparam logic [OP_WIDTH-1:0] CMP_GTE = 3'd4;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_A,
        WR_B,
        WAIT,
        READ,
        RESP
    } seq_state_e;

endpackage

// File: rtl/pu_compare_arb.sv
// Requester arbiter for the pu_compare sequencer.
// Produces a one-hot grant (plus its index) from the request vector.
// Build option PU_COMPARE_SEQ_RR_EN: round-robin with a registered pointer that
// moves past the last granted requester; otherwise fixed priority, lowest
// index first, with no state at all.
module pu_compare_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

`ifdef PU_COMPARE_SEQ_RR_EN
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    // Search for the first valid requester starting at the pointer, wrapping.
    always_comb begin : rr_search
        logic [ID_W:0] idx;
        logic          found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                grant[idx[ID_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    // Next pointer: one past the winner, wrapping at N_REQ.
    always_comb begin
        ptr_d = grant_id + 1'b1;
        if (grant_id == ID_W'(N_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    // Pointer only moves when the sequencer actually takes the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end
`else
    // seen[i] is high when any requester below index i is asking.
    logic [N_REQ:0] seen;
    assign seen[0] = 1'b0;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fixed
        assign seen[gi+1] = seen[gi] | req_valid[gi];
        assign grant[gi]  = req_valid[gi] & ~seen[gi];
    end

    // Fixed priority is purely combinational; these inputs have no role here.
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, advance, seen[N_REQ]};
`endif

    // Encode the one-hot grant into an index.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pu_compare_seq.sv
// Sequencer/arbiter sharing one pu_compare unit between N_REQ requesters.
// Accepts a request, writes both operands to the unit, waits RESULT_LAT
// cycles, reads the result back and hands it out on a valid/ready response.
// Build option PU_COMPARE_SEQ_RR_EN selects round-robin arbitration
// (default: fixed priority, lowest index wins).
module pu_compare_seq
    import pu_compare_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int N_REQ      = 4,
    parameter int RESULT_LAT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_b,
    input  logic [N_REQ*OP_WIDTH-1:0]      req_op,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(N_REQ)-1:0]       rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           pu_rst,
    output logic                           pu_signal_wr,
    output logic [DATA_WIDTH-1:0]          pu_data_in,
    output logic [ATTR_WIDTH-1:0]          pu_attr_in,
    output logic                           pu_signal_oe,
    input  logic [DATA_WIDTH-1:0]          pu_data_out,
    input  logic [ATTR_WIDTH-1:0]          pu_attr_out,
    output logic                           busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RESULT_LAT - 1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [ID_W-1:0]       gid_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [ID_W-1:0]       rsp_id_q;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_id;
    logic                  accept;
    logic [ATTR_WIDTH-1:0] op_attr;

    // Opcode goes to the unit zero-extended into the attribute field.
    assign op_attr = ATTR_WIDTH'(op_q);

    pu_compare_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    // Next-state and unit-bus decode; outputs are forced quiet while rst is high.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        req_ready    = '0;
        pu_rst       = 1'b0;
        pu_signal_wr = 1'b0;
        pu_data_in   = '0;
        pu_attr_in   = '0;
        pu_signal_oe = 1'b0;
        rsp_valid    = 1'b0;
        busy         = (state_q != IDLE) && !rst;
        case (state_q)
            INIT: begin
                pu_rst  = !rst;
                state_d = IDLE;
            end
            IDLE: begin
                if (|req_valid) begin
                    accept    = 1'b1;
                    req_ready = grant;
                    state_d   = WR_A;
                end
            end
            WR_A: begin
                pu_signal_wr = 1'b1;
                pu_data_in   = a_q;
                pu_attr_in   = op_attr;
                state_d      = WR_B;
            end
            WR_B: begin
                pu_signal_wr = 1'b1;
                pu_data_in   = b_q;
                pu_attr_in   = op_attr;
                state_d      = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = READ;
                end
            end
            READ: begin
                pu_signal_oe = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State register; reset lands in INIT so the unit gets realigned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, latency counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            gid_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            if (accept) begin
                a_q   <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                b_q   <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
                op_q  <= req_op[grant_id*OP_WIDTH +: OP_WIDTH];
                gid_q <= grant_id;
            end
            if (state_q == WR_B) begin
                cnt_q <= WAIT_LOAD;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == READ) begin
                rsp_data_q <= pu_data_out;
                rsp_id_q   <= gid_q;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

    // Only bit 0 of the unit attribute is meaningful, and only as a sanity check.
    logic unused_attr;
    assign unused_attr = ^pu_attr_out;

    // The unit should flag a valid result while its output is enabled.
    a_attr_valid: assert property (@(posedge clk) disable iff (rst)
        (state_q == READ) |-> pu_attr_out[0]);

    // Write strobe and output enable must never overlap.
    a_wr_oe_excl: assert property (@(posedge clk) disable iff (rst)
        !(pu_signal_wr && pu_signal_oe));

endmodule
